// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: latches decoded operands/control, forwards from MEM/WB,
// detects load-use hazards and inserts bubbles on flush or hazard.
module ex_operand_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_valid,
  input  logic [31:0] i_id_rs_data,
  input  logic [31:0] i_id_rt_data,
  input  logic [31:0] i_id_imm,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic [4:0]  i_id_rd,
  input  logic [1:0]  i_id_aluc,
  input  logic        i_id_alusrc,
  input  logic        i_id_uses_rt,
  input  logic        i_id_regwrite,
  input  logic        i_id_memread,
  input  logic        i_id_memwrite,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_mem_regwrite,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_result,
  input  logic        i_wb_regwrite,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_result,
  output logic [31:0] o_ex_a,
  output logic [31:0] o_ex_b,
  output logic [1:0]  o_ex_aluc,
  output logic [31:0] o_ex_store_data,
  output logic [4:0]  o_ex_rd,
  output logic        o_ex_valid,
  output logic        o_ex_regwrite,
  output logic        o_ex_memread,
  output logic        o_ex_memwrite,
  output logic        o_hazard
);

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  aluc;
    logic        alusrc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
  } ex_regs_t;

  ex_regs_t    r_ex;
  ex_regs_t    w_nxt;
  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  logic        w_hazard;

  // MEM beats WB; register 0 is hardwired and never forwarded.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  idx,
    input logic [31:0] raw,
    input logic        mem_we,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_res,
    input logic        wb_we,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_res
  );
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == idx)) begin
      fwd_sel = mem_res;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == idx)) begin
      fwd_sel = wb_res;
    end else begin
      fwd_sel = raw;
    end
  endfunction

  assign w_fwd_a = fwd_sel(r_ex.rs, r_ex.rs_data, i_mem_regwrite, i_mem_rd, i_mem_result,
                           i_wb_regwrite, i_wb_rd, i_wb_result);
  assign w_fwd_b = fwd_sel(r_ex.rt, r_ex.rt_data, i_mem_regwrite, i_mem_rd, i_mem_result,
                           i_wb_regwrite, i_wb_rd, i_wb_result);

  assign w_hazard = ~i_flush & i_id_valid & r_ex.valid & r_ex.memread & (r_ex.rd != 5'd0) &
                    ((r_ex.rd == i_id_rs) | (i_id_uses_rt & (r_ex.rd == i_id_rt)));

  // Next EX contents: flush > stall > hazard bubble > load from decode.
  always_comb begin
    w_nxt = r_ex;
    if (i_flush) begin
      w_nxt = '0;
    end else if (i_stall) begin
      // Re-capture forwarded data so a WB result retiring during the stall is kept.
      w_nxt.rs_data = w_fwd_a;
      w_nxt.rt_data = w_fwd_b;
    end else if (w_hazard) begin
      w_nxt = '0;
    end else begin
      w_nxt.valid    = i_id_valid;
      w_nxt.rs_data  = i_id_rs_data;
      w_nxt.rt_data  = i_id_rt_data;
      w_nxt.imm      = i_id_imm;
      w_nxt.rs       = i_id_rs;
      w_nxt.rt       = i_id_rt;
      w_nxt.rd       = i_id_rd;
      w_nxt.aluc     = i_id_aluc;
      w_nxt.alusrc   = i_id_alusrc;
      w_nxt.regwrite = i_id_valid & i_id_regwrite;
      w_nxt.memread  = i_id_valid & i_id_memread;
      w_nxt.memwrite = i_id_valid & i_id_memwrite;
    end
  end

  // EX register set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex <= '0;
    end else begin
      r_ex <= w_nxt;
    end
  end

  assign o_ex_a          = w_fwd_a;
  assign o_ex_b          = r_ex.alusrc ? r_ex.imm : w_fwd_b;
  assign o_ex_store_data = w_fwd_b;
  assign o_ex_aluc       = r_ex.aluc;
  assign o_ex_rd         = r_ex.rd;
  assign o_ex_valid      = r_ex.valid;
  assign o_ex_regwrite   = r_ex.regwrite;
  assign o_ex_memread    = r_ex.memread;
  assign o_ex_memwrite   = r_ex.memwrite;
  assign o_hazard        = w_hazard;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: stimulus queues expected outputs,
// a monitor pops and compares them on each falling clock edge.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_aluc;
  logic        id_alusrc, id_uses_rt, id_regwrite, id_memread, id_memwrite;
  logic        stall, flush;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [1:0]  ex_aluc;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, hazard;

  localparam int S_A = 0, S_B = 1, S_ALUC = 2, S_ST = 3, S_RD = 4, S_VAL = 5,
                 S_RW = 6, S_MR = 7, S_MW = 8, S_HZ = 9;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  ex_operand_stage dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data), .i_id_imm(id_imm),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_rd(id_rd), .i_id_aluc(id_aluc),
    .i_id_alusrc(id_alusrc), .i_id_uses_rt(id_uses_rt), .i_id_regwrite(id_regwrite),
    .i_id_memread(id_memread), .i_id_memwrite(id_memwrite),
    .i_stall(stall), .i_flush(flush),
    .i_mem_regwrite(mem_regwrite), .i_mem_rd(mem_rd), .i_mem_result(mem_result),
    .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd), .i_wb_result(wb_result),
    .o_ex_a(ex_a), .o_ex_b(ex_b), .o_ex_aluc(ex_aluc), .o_ex_store_data(ex_store_data),
    .o_ex_rd(ex_rd), .o_ex_valid(ex_valid), .o_ex_regwrite(ex_regwrite),
    .o_ex_memread(ex_memread), .o_ex_memwrite(ex_memwrite), .o_hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      S_A:     sample = ex_a;
      S_B:     sample = ex_b;
      S_ALUC:  sample = {30'd0, ex_aluc};
      S_ST:    sample = ex_store_data;
      S_RD:    sample = {27'd0, ex_rd};
      S_VAL:   sample = {31'd0, ex_valid};
      S_RW:    sample = {31'd0, ex_regwrite};
      S_MR:    sample = {31'd0, ex_memread};
      S_MW:    sample = {31'd0, ex_memwrite};
      S_HZ:    sample = {31'd0, hazard};
      default: sample = 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compare every queued expectation against the outputs at the falling edge.
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = sample(e.sel);
        n_vec++;
        if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_out(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic [31:0] imm, input logic [1:0] aluc, input logic alusrc,
                        input logic uses_rt, input logic rw, input logic mr, input logic mw);
    id_valid = v;   id_rs = rs;       id_rt = rt;       id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;   id_aluc = aluc;
    id_alusrc = alusrc; id_uses_rt = uses_rt;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  task automatic set_fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
    mem_regwrite = mrw; mem_rd = mrd; mem_result = mres;
    wb_regwrite = wrw;  wb_rd = wrd;  wb_result = wres;
  endtask

  task automatic expect_all_zero(input string nm);
    for (int s = S_A; s <= S_HZ; s++) expect_out(nm, s, 32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // Reset with an add already presented: nothing may load while rst is high.
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_all_zero("reset");

    cyc(); rst = 1'b0;
    expect_out("pre_load_valid", S_VAL, 32'd0);

    cyc();
    set_id(1'b1, 5'd4, 5'd5, 5'd7, 32'h99, 32'h33, 32'd0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("add_a", S_A, 32'd5);
    expect_out("add_b", S_B, 32'd7);
    expect_out("add_aluc", S_ALUC, 32'd0);
    expect_out("add_valid", S_VAL, 32'd1);
    expect_out("add_rd", S_RD, 32'd3);
    expect_out("add_regwrite", S_RW, 32'd1);

    cyc(); set_fwd(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
    expect_out("fwd_mem_over_wb", S_A, 32'h11);
    expect_out("fwd_b_nomatch", S_B, 32'h33);
    expect_out("fwd_aluc", S_ALUC, 32'd1);

    cyc(); set_fwd(1'b0, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
    expect_out("fwd_wb", S_A, 32'h22);

    cyc(); set_fwd(1'b1, 5'd5, 32'h44, 1'b0, 5'd0, 32'd0);
    expect_out("fwd_a_raw", S_A, 32'h99);
    expect_out("fwd_mem_b", S_B, 32'h44);
    expect_out("fwd_mem_store", S_ST, 32'h44);

    cyc(); set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 32'h0A, 32'h0B, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("nofwd_a", S_A, 32'h99);
    expect_out("nofwd_b", S_B, 32'h33);

    cyc(); set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
    set_id(1'b1, 5'd10, 5'd9, 5'd11, 32'd3, 32'd9, 32'hFFFF_FFFC, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("r0_a", S_A, 32'h0A);
    expect_out("r0_b", S_B, 32'h0B);

    cyc(); set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd1, 5'd0, 5'd8, 32'h100, 32'd0, 32'd4, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("imm_b", S_B, 32'hFFFF_FFFC);
    expect_out("imm_store", S_ST, 32'd9);
    expect_out("imm_a", S_A, 32'd3);
    expect_out("imm_aluc", S_ALUC, 32'd2);
    expect_out("imm_hazard", S_HZ, 32'd0);

    cyc();
    set_id(1'b1, 5'd8, 5'd2, 5'd12, 32'h7, 32'h6, 32'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("lu_hazard", S_HZ, 32'd1);
    expect_out("lu_memread", S_MR, 32'd1);
    expect_out("lu_a", S_A, 32'h100);
    expect_out("lu_b", S_B, 32'd4);
    expect_out("lu_rd", S_RD, 32'd8);

    cyc(); set_fwd(1'b1, 5'd8, 32'hABC, 1'b0, 5'd0, 32'd0);
    expect_out("bubble_valid", S_VAL, 32'd0);
    expect_out("bubble_regwrite", S_RW, 32'd0);
    expect_out("bubble_memread", S_MR, 32'd0);
    expect_out("bubble_hazard", S_HZ, 32'd0);
    expect_out("bubble_a", S_A, 32'd0);

    cyc();
    set_id(1'b1, 5'd6, 5'd0, 5'd13, 32'd1, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("dep_fwd_a", S_A, 32'hABC);
    expect_out("dep_b", S_B, 32'h6);
    expect_out("dep_valid", S_VAL, 32'd1);
    expect_out("dep_rd", S_RD, 32'd12);
    expect_out("dep_hazard", S_HZ, 32'd0);

    cyc(); stall = 1'b1; set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h55);
    set_id(1'b1, 5'd1, 5'd0, 5'd14, 32'hDEAD, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("stall_n_a", S_A, 32'h55);
    expect_out("stall_n_rd", S_RD, 32'd13);

    cyc(); set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    expect_out("stall_n1_a", S_A, 32'h55);
    expect_out("stall_n1_rd", S_RD, 32'd13);

    cyc(); stall = 1'b0;
    set_id(1'b1, 5'd2, 5'd0, 5'd9, 32'h200, 32'd0, 32'd8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("unstall_a", S_A, 32'h55);
    expect_out("unstall_rd", S_RD, 32'd13);

    cyc(); stall = 1'b1;
    set_id(1'b1, 5'd9, 5'd3, 5'd15, 32'h1, 32'h2, 32'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("stallhz_hazard", S_HZ, 32'd1);
    expect_out("stallhz_memread", S_MR, 32'd1);
    expect_out("stallhz_rd", S_RD, 32'd9);

    cyc(); flush = 1'b1;
    expect_out("flush_hazard_forced0", S_HZ, 32'd0);
    expect_out("held_load_valid", S_VAL, 32'd1);
    expect_out("held_load_rd", S_RD, 32'd9);
    expect_out("held_load_b", S_B, 32'd8);

    cyc(); flush = 1'b0; stall = 1'b0;
    expect_out("flush_valid", S_VAL, 32'd0);
    expect_out("flush_memread", S_MR, 32'd0);
    expect_out("flush_regwrite", S_RW, 32'd0);
    expect_out("flush_hazard", S_HZ, 32'd0);

    cyc(); stall = 1'b1;
    expect_out("prerst_valid", S_VAL, 32'd1);
    expect_out("prerst_rd", S_RD, 32'd15);

    cyc(); rst = 1'b1;
    expect_all_zero("midstall_reset");

    cyc(); rst = 1'b0; stall = 1'b0;
    set_id(1'b1, 5'd7, 5'd0, 5'd5, 32'h21, 32'd0, 32'd0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("postrst_valid", S_VAL, 32'd0);

    cyc();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("reload_valid", S_VAL, 32'd1);
    expect_out("reload_a", S_A, 32'h21);
    expect_out("reload_rd", S_RD, 32'd5);
    expect_out("reload_aluc", S_ALUC, 32'd3);
    expect_out("reload_memwrite", S_MW, 32'd1);

    cyc();
    n_vec++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
